// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with independent push/pop, same-cycle top replace,
// occupancy count, almost-full threshold and sticky overflow/underflow flags.
module lifo_stack_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         EN,
    input  logic                         PUSH,
    input  logic                         POP,
    input  logic                         CLR_ERR,
    input  logic [DATA_W-1:0]            dataIn,
    output logic [DATA_W-1:0]            dataOut,
    output logic                         dataValid,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         ALMOST_FULL,
    output logic                         OVF,
    output logic                         UDF
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_dv;
    logic              r_empty;
    logic              r_full;
    logic              r_afull;
    logic              r_ovf;
    logic              r_udf;

    logic              w_do_pop;
    logic              w_do_push;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic [AW-1:0]     w_top;
    logic [AW-1:0]     w_widx;
    logic [CW-1:0]     w_cnt_nxt;

    // A push alongside an accepted pop always fits: it overwrites the old top.
    assign w_do_pop  = EN & POP & ~r_empty;
    assign w_do_push = EN & PUSH & (~r_full | w_do_pop);
    assign w_ovf_set = EN & PUSH & ~POP & r_full;
    assign w_udf_set = EN & POP & r_empty;
    assign w_top     = r_count[AW-1:0] - AW'(1);
    assign w_widx    = w_do_pop ? w_top : r_count[AW-1:0];

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_cnt_nxt = r_count + CW'(1);
            2'b01:   w_cnt_nxt = r_count - CW'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_do_push)
            r_mem[w_widx] <= dataIn;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
            r_dout  <= '0;
            r_dv    <= 1'b0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_dv    <= w_do_pop;
            if (w_do_pop)
                r_dout <= r_mem[w_top];
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            r_afull <= (w_cnt_nxt >= CW'(AFULL_LVL));
            // Error set wins over a same-cycle clear.
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (CLR_ERR) r_ovf <= 1'b0;
            if (w_udf_set)    r_udf <= 1'b1;
            else if (CLR_ERR) r_udf <= 1'b0;
        end
    end

    assign dataOut     = r_dout;
    assign dataValid   = r_dv;
    assign COUNT       = r_count;
    assign EMPTY       = r_empty;
    assign FULL        = r_full;
    assign ALMOST_FULL = r_afull;
    assign OVF         = r_ovf;
    assign UDF         = r_udf;
endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed + random checks of lifo_stack_param (DATA_W=8, DEPTH=4) against a queue model.
module tb_lifo_stack_param;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AF = DP - 1;

    logic          Clk, Rst_n, EN, PUSH, POP, CLR_ERR;
    logic [DW-1:0] dataIn, dataOut;
    logic          dataValid, EMPTY, FULL, ALMOST_FULL, OVF, UDF;
    logic [2:0]    COUNT;

    lifo_stack_param #(.DATA_W(DW), .DEPTH(DP)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .EN(EN), .PUSH(PUSH), .POP(POP),
        .CLR_ERR(CLR_ERR), .dataIn(dataIn), .dataOut(dataOut),
        .dataValid(dataValid), .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .OVF(OVF), .UDF(UDF)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          passed = 0;
    int          total  = 0;
    logic [7:0]  mq[$];
    logic [7:0]  m_dout;
    logic        m_dv, m_ovf, m_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(COUNT), 32'(mq.size()));
        chk({tag, ".dout"},  32'(dataOut), 32'(m_dout));
        chk({tag, ".dv"},    32'(dataValid), 32'(m_dv));
        chk({tag, ".empty"}, 32'(EMPTY), 32'(mq.size() == 0));
        chk({tag, ".full"},  32'(FULL), 32'(mq.size() == DP));
        chk({tag, ".afull"}, 32'(ALMOST_FULL), 32'(mq.size() >= AF));
        chk({tag, ".ovf"},   32'(OVF), 32'(m_ovf));
        chk({tag, ".udf"},   32'(UDF), 32'(m_udf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic pu, input logic po,
                              input logic clr, input logic [7:0] din);
        logic ovf_s, udf_s;
        ovf_s = 1'b0; udf_s = 1'b0; m_dv = 1'b0;
        if (en) begin
            if (pu && po) begin
                if (mq.size() > 0) begin
                    m_dout = mq[mq.size()-1];
                    mq[mq.size()-1] = din;
                    m_dv = 1'b1;
                end else begin
                    udf_s = 1'b1;
                    mq.push_back(din);
                end
            end else if (pu) begin
                if (mq.size() == DP) ovf_s = 1'b1;
                else mq.push_back(din);
            end else if (po) begin
                if (mq.size() == 0) udf_s = 1'b1;
                else begin
                    m_dout = mq.pop_back();
                    m_dv = 1'b1;
                end
            end
        end
        m_ovf = ovf_s ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_udf = udf_s ? 1'b1 : (clr ? 1'b0 : m_udf);
    endtask

    // Called just after a rising edge; applies inputs for the next edge and checks after it.
    task automatic cyc(input string tag, input logic en, input logic pu, input logic po,
                       input logic clr, input logic [7:0] din);
        EN = en; PUSH = pu; POP = po; CLR_ERR = clr; dataIn = din;
        @(posedge Clk);
        #1;
        model_step(en, pu, po, clr, din);
        chk_all(tag);
    endtask

    initial begin
        Rst_n = 1'b0; EN = 1'b0; PUSH = 1'b0; POP = 1'b0; CLR_ERR = 1'b0; dataIn = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk_all("reset");
        Rst_n = 1'b1;

        // fill to full, then drain in reverse order
        cyc("push11", 1, 1, 0, 0, 8'h11);
        cyc("push22", 1, 1, 0, 0, 8'h22);
        cyc("push33", 1, 1, 0, 0, 8'h33);
        chk("afull_at3", 32'(ALMOST_FULL), 32'd1);
        cyc("push44", 1, 1, 0, 0, 8'h44);
        chk("full_at4", 32'(FULL), 32'd1);
        cyc("ovf55", 1, 1, 0, 0, 8'h55);
        chk("ovf_set", 32'(OVF), 32'd1);
        cyc("pop44", 1, 0, 1, 0, 8'h00);
        chk("pop44_val", 32'(dataOut), 32'h44);
        cyc("clr_ovf", 1, 0, 0, 1, 8'h00);
        chk("ovf_clr", 32'(OVF), 32'd0);
        cyc("pop33", 1, 0, 1, 0, 8'h00);
        cyc("pop22", 1, 0, 1, 0, 8'h00);
        cyc("pop11", 1, 0, 1, 0, 8'h00);
        chk("pop11_val", 32'(dataOut), 32'h11);
        chk("empty_last", 32'(EMPTY), 32'd1);

        // underflow and push+pop on empty
        cyc("udf_pop", 1, 0, 1, 0, 8'h00);
        chk("udf_hold", 32'(dataOut), 32'h11);
        cyc("pp_empty", 1, 1, 1, 0, 8'h66);
        chk("pp_empty_cnt", 32'(COUNT), 32'd1);
        cyc("pop66", 1, 0, 1, 0, 8'h00);
        chk("pop66_val", 32'(dataOut), 32'h66);
        cyc("clr_set_wins", 1, 0, 1, 1, 8'h00);
        cyc("clr_udf", 1, 0, 0, 1, 8'h00);

        // top replace
        cyc("push11b", 1, 1, 0, 0, 8'h11);
        cyc("push22b", 1, 1, 0, 0, 8'h22);
        cyc("repl99", 1, 1, 1, 0, 8'h99);
        chk("repl_dout", 32'(dataOut), 32'h22);
        cyc("pop99", 1, 0, 1, 0, 8'h00);
        chk("pop99_val", 32'(dataOut), 32'h99);
        cyc("pop11b", 1, 0, 1, 0, 8'h00);

        // enable low: requests ignored, clear still acts
        cyc("mk_udf", 1, 0, 1, 0, 8'h00);
        cyc("push77", 1, 1, 0, 0, 8'h77);
        for (int i = 0; i < 3; i++) cyc("en_low", 0, 1, 1, 0, 8'hAA);
        cyc("en_low_clr", 0, 0, 0, 1, 8'h00);
        chk("en_low_udf", 32'(UDF), 32'd0);

        // full-stack replace, then async reset between edges with COUNT=3
        cyc("push_a", 1, 1, 0, 0, 8'hA1);
        cyc("push_b", 1, 1, 0, 0, 8'hB2);
        cyc("push_c", 1, 1, 0, 0, 8'hC3);
        cyc("repl_full", 1, 1, 1, 0, 8'hD4);
        cyc("pop_d4", 1, 0, 1, 0, 8'h00);
        EN = 1'b0; PUSH = 1'b0; POP = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        #4;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        cyc("post_rst_pop", 1, 0, 1, 0, 8'h00);
        chk("post_rst_udf", 32'(UDF), 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, ($urandom_range(0, 15) == 0), 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
